// File: rtl/cache_refill_arbiter_if.sv
// cache_refill_arbiter_if
//   Bundles the signals between the refill arbiter, the two cache miss
//   handlers and the single main-memory word port.
//   Cache side  : ic_req/ic_addr, dc_req/dc_wb/dc_addr/dc_wb_addr/dc_wdata in;
//                 rvalid/done/windex/stall per cache and shared refill_data out.
//   Memory side : mem_req/mem_we/mem_addr/mem_wdata out; mem_rdata/mem_ack in.
//   Misc        : busy (arbiter not idle).
//   Modports    : master = arbiter view, slave = caches + memory view.
interface cache_refill_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              dc_req;
  logic              dc_wb;
  logic [ADDR_W-1:0] dc_addr;
  logic [ADDR_W-1:0] dc_wb_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              ic_rvalid;
  logic              ic_done;
  logic              dc_rvalid;
  logic              dc_done;
  logic [DATA_W-1:0] refill_data;
  logic [IDX_W-1:0]  ic_windex;
  logic [IDX_W-1:0]  dc_windex;
  logic              ic_stall;
  logic              dc_stall;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_wb, dc_addr, dc_wb_addr, dc_wdata,
           mem_rdata, mem_ack,
    output ic_rvalid, ic_done, dc_rvalid, dc_done, refill_data,
           ic_windex, dc_windex, ic_stall, dc_stall, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_wb, dc_addr, dc_wb_addr, dc_wdata,
           mem_rdata, mem_ack,
    input  ic_rvalid, ic_done, dc_rvalid, dc_done, refill_data,
           ic_windex, dc_windex, ic_stall, dc_stall, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one main-memory word port between the ICache and DCache miss
//   handlers. DCache has fixed priority (its miss belongs to the older
//   instruction). A DCache miss with a dirty victim first writes the victim
//   line back, then refills, with no gap in mem_req between the two bursts.
//   Ports:
//     CPU_CLK   : rising-edge clock
//     CPU_RST_N : asynchronous active-low reset
//     bus       : cache_refill_arbiter_if.master (cache and memory handshakes)
module cache_refill_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST_N,
  cache_refill_arbiter_if.master bus
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);

  // Clears the byte-within-line bits so a burst always starts at word 0.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DC_WB = 2'd1;
  localparam logic [1:0] DC_RD = 2'd2;
  localparam logic [1:0] IC_RD = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic [IDX_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  cnt_nx_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] base_nx_s;
  logic [ADDR_W-1:0] wb_base_r;
  logic [ADDR_W-1:0] wb_base_nx_s;

  logic              in_burst_s;
  logic              in_read_s;
  logic              last_beat_s;
  logic              ic_done_s;
  logic              dc_done_s;
  logic [ADDR_W-1:0] word_off_s;

  assign in_burst_s  = (state_r != IDLE);
  assign in_read_s   = (state_r == DC_RD) || (state_r == IC_RD);
  assign last_beat_s = bus.mem_ack && (cnt_r == LAST_IDX);
  assign word_off_s  = ADDR_W'(cnt_r) * ADDR_W'(WORD_BYTES);

  // Arbitration in IDLE and beat/line sequencing during bursts.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    base_nx_s    = base_r;
    wb_base_nx_s = wb_base_r;
    case (state_r)
      IDLE: begin
        if (bus.dc_req) begin
          state_nx_s   = bus.dc_wb ? DC_WB : DC_RD;
          cnt_nx_s     = IDX_ZERO;
          base_nx_s    = bus.dc_addr & LINE_MASK;
          wb_base_nx_s = bus.dc_wb_addr & LINE_MASK;
        end else if (bus.ic_req) begin
          state_nx_s   = IC_RD;
          cnt_nx_s     = IDX_ZERO;
          base_nx_s    = bus.ic_addr & LINE_MASK;
          wb_base_nx_s = bus.dc_wb_addr & LINE_MASK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DC_WB, DC_RD, IC_RD: begin
        if (last_beat_s) begin
          cnt_nx_s = IDX_ZERO;
          // Writeback chains straight into the refill so mem_req never drops.
          state_nx_s = (state_r == DC_WB) ? DC_RD : IDLE;
        end else if (bus.mem_ack) begin
          cnt_nx_s = cnt_r + IDX_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = IDX_ZERO;
      end
    endcase
  end

  // State and burst-address registers; reset abandons any in-flight word.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_r   <= IDLE;
      cnt_r     <= IDX_ZERO;
      base_r    <= {ADDR_W{1'b0}};
      wb_base_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      base_r    <= base_nx_s;
      wb_base_r <= wb_base_nx_s;
    end
  end

  // Memory port: address walks the line from the latched base.
  assign bus.mem_req   = in_burst_s;
  assign bus.mem_we    = (state_r == DC_WB);
  assign bus.mem_addr  = !in_burst_s        ? {ADDR_W{1'b0}} :
                         (state_r == DC_WB) ? (wb_base_r + word_off_s) :
                                              (base_r + word_off_s);
  assign bus.mem_wdata = (state_r == DC_WB) ? bus.dc_wdata : {DATA_W{1'b0}};

  // Read beats and line completion, coincident with the memory ack.
  assign ic_done_s       = (state_r == IC_RD) && last_beat_s;
  assign dc_done_s       = (state_r == DC_RD) && last_beat_s;
  assign bus.ic_rvalid   = (state_r == IC_RD) && bus.mem_ack;
  assign bus.dc_rvalid   = (state_r == DC_RD) && bus.mem_ack;
  assign bus.ic_done     = ic_done_s;
  assign bus.dc_done     = dc_done_s;
  // Only meaningful with rvalid; held at zero outside read bursts.
  assign bus.refill_data = in_read_s ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.ic_windex   = (state_r == IC_RD) ? cnt_r : IDX_ZERO;
  assign bus.dc_windex   = ((state_r == DC_WB) || (state_r == DC_RD)) ? cnt_r : IDX_ZERO;

  // Stalls drop in the done cycle so the pipeline resumes on the next edge.
  assign bus.ic_stall = bus.ic_req & ~ic_done_s;
  assign bus.dc_stall = bus.dc_req & ~dc_done_s;
  assign bus.busy     = in_burst_s;

endmodule
